// File: rtl/int_mult_54x54.sv
// Pipelined 54x54 unsigned multiplier built from 18x18 limb tiles.
// Latency is 4 cycles to the full product and 3 cycles to the early low word.
// A new operand pair is accepted every cycle; there is no stall or backpressure.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   mult_a, mult_b           operands (K bits), captured every cycle
//   in_valid                 qualifies the operand pair; carried along with the data
//   int_mult_result          full 2K-bit product, 4 cycles after capture
//   int_mult_result_low      product bits [W-1:0], 3 cycles after capture
//   low_valid, out_valid     in_valid delayed by 3 and 4 cycles
module int_mult_54x54 #(
    parameter int unsigned K = 54,
    parameter int unsigned W = 24,
    parameter int unsigned L = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [K-1:0]     mult_a,
    input  logic [K-1:0]     mult_b,
    input  logic             in_valid,
    output logic [2*K-1:0]   int_mult_result,
    output logic [W-1:0]     int_mult_result_low,
    output logic             low_valid,
    output logic             out_valid
);

    localparam int unsigned PW  = 2 * L;   // partial product width
    localparam int unsigned RW  = 2 * K;   // full product width
    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = W - L;   // bits of column 1 that land below W

    // S1: operand capture
    logic [K-1:0] a_r, b_r;
    logic         v1_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            v1_r <= 1'b0;
        end else begin
            a_r  <= mult_a;
            b_r  <= mult_b;
            v1_r <= in_valid;
        end
    end

    // S2: nine limb products, one DSP tile each
    logic [PW-1:0] p_r [3][3];
    logic          v2_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    p_r[i][j] <= '0;
                end
            end
            v2_r <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    p_r[i][j] <= PW'(a_r[i*L +: L]) * PW'(b_r[j*L +: L]);
                end
            end
            v2_r <= v1_r;
        end
    end

    // Early low word: only p00 and the low CW bits of column 1 reach below bit W
    logic [CW-1:0] c1_part_c;
    logic [W-1:0]  low_c;

    always_comb begin
        c1_part_c = CW'(p_r[0][1]) + CW'(p_r[1][0]);
        low_c     = W'(p_r[0][0]) + {c1_part_c, L'(0)};
    end

    // S3: column sums plus the early low word
    logic [PW-1:0] c0_r;
    logic [PW:0]   c1_r;
    logic [PW+1:0] c2_r;
    logic [PW:0]   c3_r;
    logic [PW-1:0] c4_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            c0_r                <= '0;
            c1_r                <= '0;
            c2_r                <= '0;
            c3_r                <= '0;
            c4_r                <= '0;
            int_mult_result_low <= '0;
            low_valid           <= 1'b0;
        end else begin
            c0_r                <= p_r[0][0];
            c1_r                <= (PW+1)'(p_r[0][1]) + (PW+1)'(p_r[1][0]);
            c2_r                <= (PW+2)'(p_r[0][2]) + (PW+2)'(p_r[1][1]) + (PW+2)'(p_r[2][0]);
            c3_r                <= (PW+1)'(p_r[1][2]) + (PW+1)'(p_r[2][1]);
            c4_r                <= p_r[2][2];
            int_mult_result_low <= low_c;
            low_valid           <= v2_r;
        end
    end

    // S4: final carry-propagating sum across all columns
    always_ff @(posedge clk) begin
        if (rst) begin
            int_mult_result <= '0;
            out_valid       <= 1'b0;
        end else begin
            int_mult_result <= RW'(c0_r)
                             + (RW'(c1_r) << L)
                             + (RW'(c2_r) << (2*L))
                             + (RW'(c3_r) << (3*L))
                             + (RW'(c4_r) << (4*L));
            out_valid       <= low_valid;
        end
    end

endmodule

// File: tb/tb_int_mult_54x54.sv
// Bench for int_mult_54x54: per-cycle input history plus a product model,
// one compare process at the falling edge, and literal pins on directed cases.
module tb_int_mult_54x54;

    localparam int unsigned K     = 54;
    localparam int unsigned W     = 24;
    localparam int unsigned RW    = 2 * K;
    localparam int unsigned NCYC  = 2048;

    logic           clk;
    logic           rst;
    logic [K-1:0]   mult_a, mult_b;
    logic           in_valid;
    logic [RW-1:0]  int_mult_result;
    logic [W-1:0]   int_mult_result_low;
    logic           low_valid, out_valid;

    int_mult_54x54 dut (
        .clk                 (clk),
        .rst                 (rst),
        .mult_a              (mult_a),
        .mult_b              (mult_b),
        .in_valid            (in_valid),
        .int_mult_result     (int_mult_result),
        .int_mult_result_low (int_mult_result_low),
        .low_valid           (low_valid),
        .out_valid           (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input history indexed by cycle number
    logic [K-1:0]  a_h   [NCYC];
    logic [K-1:0]  b_h   [NCYC];
    logic          v_h   [NCYC];
    logic          rst_h [NCYC];
    logic          pin_res_en [NCYC];
    logic [RW-1:0] pin_res    [NCYC];
    logic          pin_low_en [NCYC];
    logic [W-1:0]  pin_low    [NCYC];

    int cyc;
    int n_chk;
    int n_fail;
    bit running;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply inputs for the current cycle and record them
    task automatic apply(input logic [K-1:0] a, input logic [K-1:0] b,
                         input logic v, input logic r,
                         input logic pin, input logic [RW-1:0] pres, input logic [W-1:0] plow);
        mult_a   = a;
        mult_b   = b;
        in_valid = v;
        rst      = r;
        if (cyc + 4 >= NCYC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
            $fatal(1);
        end
        a_h[cyc]   = a;
        b_h[cyc]   = b;
        v_h[cyc]   = v;
        rst_h[cyc] = r;
        if (pin) begin
            pin_res_en[cyc+4] = 1'b1;
            pin_res[cyc+4]    = pres;
            pin_low_en[cyc+3] = 1'b1;
            pin_low[cyc+3]    = plow;
        end
    endtask

    task automatic step(input logic [K-1:0] a, input logic [K-1:0] b,
                        input logic v, input logic r);
        @(posedge clk);
        #1;
        apply(a, b, v, r, 1'b0, '0, '0);
    endtask

    task automatic step_pin(input logic [K-1:0] a, input logic [K-1:0] b,
                            input logic [RW-1:0] pres, input logic [W-1:0] plow);
        @(posedge clk);
        #1;
        apply(a, b, 1'b1, 1'b0, 1'b1, pres, plow);
    endtask

    function automatic logic [K-1:0] rnd54();
        return K'({$urandom, $urandom});
    endfunction

    // Model: output at cycle t reflects the inputs of cycle t-d unless a reset
    // was sampled at any edge in between, in which case everything reads zero.
    task automatic expect_at(input int t, input int d,
                             output logic [RW-1:0] prod, output logic v);
        bit killed;
        killed = 1'b0;
        for (int i = t - d; i < t; i++) begin
            if (i < 0 || rst_h[i]) killed = 1'b1;
        end
        if (killed) begin
            prod = '0;
            v    = 1'b0;
        end else begin
            prod = RW'(a_h[t-d]) * RW'(b_h[t-d]);
            v    = v_h[t-d];
        end
    endtask

    always @(negedge clk) begin
        logic [RW-1:0] er, el;
        logic          evr, evl;
        if (running && cyc >= 1) begin
            expect_at(cyc, 4, er, evr);
            expect_at(cyc, 3, el, evl);
            n_chk += 4;
            if (out_valid !== evr) begin
                n_fail++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, evr);
            end
            if (low_valid !== evl) begin
                n_fail++;
                $display("FAIL low_valid cyc=%0d got=%b exp=%b", cyc, low_valid, evl);
            end
            if (int_mult_result !== er) begin
                n_fail++;
                $display("FAIL result cyc=%0d got=%h exp=%h", cyc, int_mult_result, er);
            end
            if (int_mult_result_low !== W'(el)) begin
                n_fail++;
                $display("FAIL low cyc=%0d got=%h exp=%h", cyc, int_mult_result_low, W'(el));
            end
            if (pin_res_en[cyc]) begin
                n_chk += 2;
                if (int_mult_result !== pin_res[cyc]) begin
                    n_fail++;
                    $display("FAIL pin_result cyc=%0d got=%h exp=%h", cyc, int_mult_result, pin_res[cyc]);
                end
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pin_out_valid cyc=%0d got=%b exp=1", cyc, out_valid);
                end
            end
            if (pin_low_en[cyc]) begin
                n_chk += 2;
                if (int_mult_result_low !== pin_low[cyc]) begin
                    n_fail++;
                    $display("FAIL pin_low cyc=%0d got=%h exp=%h", cyc, int_mult_result_low, pin_low[cyc]);
                end
                if (low_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pin_low_valid cyc=%0d got=%b exp=1", cyc, low_valid);
                end
            end
        end
    end

    initial begin
        logic [K-1:0] amax;
        logic [K-1:0] a53;
        cyc     = 0;
        n_chk   = 0;
        n_fail  = 0;
        running = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            a_h[i] = '0; b_h[i] = '0; v_h[i] = 1'b0; rst_h[i] = 1'b0;
            pin_res_en[i] = 1'b0; pin_res[i] = '0;
            pin_low_en[i] = 1'b0; pin_low[i] = '0;
        end
        amax = '1;
        a53  = K'(1) << 53;

        // Reset for two cycles, then idle with zero operands
        apply('0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, 1'b0);

        // Simple product and latency, isolated by idle cycles
        step_pin(K'(3), K'(5), RW'(15), W'(24'h00000F));
        for (int i = 0; i < 6; i++) step('0, '0, 1'b0, 1'b0);

        // Limb-boundary carries and maximum operands
        step_pin(K'(54'h3FFFF), K'(54'h40000), RW'(108'hFFFFC0000), W'(24'hFC0000));
        step_pin(a53, K'(2), RW'(1) << 54, '0);
        step_pin(amax, amax, 108'hFFFFFFFFFFFFF80000000000001, W'(24'h000001));
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, 1'b0);

        // Back-to-back random stream with occasional bubbles
        for (int i = 0; i < 1000; i++) begin
            step(rnd54(), rnd54(), ($urandom_range(0, 7) != 0), 1'b0);
        end
        for (int i = 0; i < 5; i++) step('0, '0, 1'b0, 1'b0);

        // Reset mid-flight: three valid pairs, reset on the third, then 7*9
        step(rnd54(), rnd54(), 1'b1, 1'b0);
        step(rnd54(), rnd54(), 1'b1, 1'b0);
        step(rnd54(), rnd54(), 1'b1, 1'b1);
        step_pin(K'(7), K'(9), RW'(63), W'(63));
        for (int i = 0; i < 8; i++) step('0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
